// File: rtl/div_result_bcd_formatter.sv
// div_result_bcd_formatter
// Captures the restoring divider's quotient/remainder on the rising edge of
// its level `done`, converts both to packed BCD with a bit-serial double
// dabble engine (one bit per cycle), and offers the result on valid/ready.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_done           divider done level; 0->1 marks a new result
//   in_quotient       divider quotient (WIDTH)
//   in_remainder      divider remainder (WIDTH)
//   in_divisor        divisor seen by the divider (divide-by-zero flag only)
//   out_ready         downstream accepts the result
//   out_valid         BCD result available
//   q_bcd, r_bcd      packed BCD quotient/remainder, digit 0 in [3:0]
//   busy              converting or holding a result
//   out_err           divide-by-zero flag
//
// Optional feature macro: BCD_DIVZERO_EN (divide-by-zero flag and all-ones
// result marker). When undefined, in_divisor is ignored and out_err is 0.
module div_result_bcd_formatter #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_done,
   input  logic [WIDTH-1:0]      in_quotient,
   input  logic [WIDTH-1:0]      in_remainder,
   input  logic [WIDTH-1:0]      in_divisor,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [4*DIGITS-1:0]   q_bcd,
   output logic [4*DIGITS-1:0]   r_bcd,
   output logic                  busy,
   output logic                  out_err
);

   localparam int unsigned BW = 4 * DIGITS;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   // DIGITS must be able to hold the largest WIDTH-bit value.
   function automatic bit digits_ok();
      longint unsigned p;
      p = 64'd1;
      for (int unsigned i = 0; i < DIGITS; i++) p = p * 64'd10;
      return p > ((64'd1 << WIDTH) - 64'd1);
   endfunction

   localparam bit DIGITS_OK = digits_ok();

   if (!DIGITS_OK) begin : g_bad_digits
      $error("div_result_bcd_formatter: DIGITS too small for WIDTH");
   end

   // Add 3 to every BCD digit >= 5, no carry between digits.
   function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
      logic [BW-1:0] r;
      r = v;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (v[4*d +: 4] >= 4'd5) r[4*d +: 4] = v[4*d +: 4] + 4'd3;
      end
      return r;
   endfunction

   typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

   state_t           state, state_nxt;
   logic             done_prev;
   logic             rise;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] q_bin, r_bin, q_bin_nxt, r_bin_nxt;
   logic [BW-1:0]    q_acc, r_acc, q_acc_nxt, r_acc_nxt;

   assign rise = in_done & ~done_prev;

   // One double dabble step: correct digits, then shift {bcd,bin} left.
   always_comb begin
      {q_acc_nxt, q_bin_nxt} = {add3(q_acc), q_bin} << 1;
      {r_acc_nxt, r_bin_nxt} = {add3(r_acc), r_bin} << 1;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; HOLD implies out_valid, so out_ready alone completes it.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rise) state_nxt = CONV;
         CONV:    if (cnt == CW'(1)) state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef BCD_DIVZERO_EN
   logic err_pend;
`else
   logic unused_divisor;
   assign unused_divisor = ^in_divisor;
   assign out_err        = 1'b0;
`endif

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         done_prev <= 1'b1;       // done already high at release is not a rise
         cnt       <= '0;
         q_bin     <= '0;
         r_bin     <= '0;
         q_acc     <= '0;
         r_acc     <= '0;
         q_bcd     <= '0;
         r_bcd     <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
`ifdef BCD_DIVZERO_EN
         err_pend  <= 1'b0;
         out_err   <= 1'b0;
`endif
      end else begin
         done_prev <= in_done;
         case (state)
            IDLE: begin
               if (rise) begin
                  q_bin <= in_quotient;
                  r_bin <= in_remainder;
                  q_acc <= '0;
                  r_acc <= '0;
                  cnt   <= CW'(WIDTH);
                  busy  <= 1'b1;
`ifdef BCD_DIVZERO_EN
                  err_pend <= (in_divisor == '0);
`endif
               end
            end
            CONV: begin
               q_acc <= q_acc_nxt;
               r_acc <= r_acc_nxt;
               q_bin <= q_bin_nxt;
               r_bin <= r_bin_nxt;
               cnt   <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  out_valid <= 1'b1;
`ifdef BCD_DIVZERO_EN
                  out_err <= err_pend;
                  q_bcd   <= err_pend ? '1 : q_acc_nxt;
                  r_bcd   <= err_pend ? '1 : r_acc_nxt;
`else
                  q_bcd   <= q_acc_nxt;
                  r_bcd   <= r_acc_nxt;
`endif
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
`ifdef BCD_DIVZERO_EN
                  out_err   <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_result_bcd_formatter.sv
// Self-checking bench for div_result_bcd_formatter (WIDTH=8, DIGITS=3).
// Expected BCD values come from decimal digit extraction of the inputs.
module tb_div_result_bcd_formatter;

   logic        clk;
   logic        reset;
   logic        in_done;
   logic [7:0]  in_quotient;
   logic [7:0]  in_remainder;
   logic [7:0]  in_divisor;
   logic        out_ready;
   logic        out_valid;
   logic [11:0] q_bcd;
   logic [11:0] r_bcd;
   logic        busy;
   logic        out_err;

   int passed = 0;
   int total  = 0;

   div_result_bcd_formatter #(.WIDTH(8), .DIGITS(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_done      (in_done),
      .in_quotient  (in_quotient),
      .in_remainder (in_remainder),
      .in_divisor   (in_divisor),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .q_bcd        (q_bcd),
      .r_bcd        (r_bcd),
      .busy         (busy),
      .out_err      (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: decimal digits of v, least significant digit in [3:0].
   function automatic logic [11:0] to_bcd(input int unsigned v);
      logic [11:0] b;
      b = '0;
      for (int d = 0; d < 3; d++) begin
         b[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return b;
   endfunction

   // One full transaction: fresh rise, latency, held result, handshake.
   task automatic do_txn(input logic [7:0] q, input logic [7:0] r,
                         input logic [7:0] dv, input int delay,
                         input bit rise_hs, input string name);
      logic [11:0] eq, er;
      logic        ee;
      int          lat;
      bit          bad;
      ee = 1'b0;
      eq = to_bcd(q);
      er = to_bcd(r);
`ifdef BCD_DIVZERO_EN
      if (dv == 8'd0) begin
         ee = 1'b1;
         eq = 12'hFFF;
         er = 12'hFFF;
      end
`endif
      @(negedge clk);
      in_done   = 1'b0;
      out_ready = (delay == 0);
      @(negedge clk);
      in_quotient  = q;
      in_remainder = r;
      in_divisor   = dv;
      in_done      = 1'b1;
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b1) $display("FAIL %s busy_after_capture got %b exp 1", name, busy);
      else passed++;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) begin
            lat = k;
            break;
         end
      end
      total++;
      if (lat != 8) $display("FAIL %s latency got %0d exp 8", name, lat);
      else passed++;
      total++;
      if (q_bcd !== eq || r_bcd !== er || out_err !== ee)
         $display("FAIL %s result got q=%h r=%h err=%b exp q=%h r=%h err=%b",
                  name, q_bcd, r_bcd, out_err, eq, er, ee);
      else passed++;
      bad = 1'b0;
      for (int d = 0; d < delay; d++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || q_bcd !== eq || r_bcd !== er || out_err !== ee) bad = 1'b1;
      end
      if (rise_hs) begin
         @(negedge clk);
         in_done = 1'b0;
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || q_bcd !== eq || r_bcd !== er) bad = 1'b1;
      end
      if (delay > 0 || rise_hs) begin
         total++;
         if (bad) $display("FAIL %s hold_stable got q=%h valid=%b exp q=%h valid=1",
                           name, q_bcd, out_valid, eq);
         else passed++;
      end
      @(negedge clk);
      out_ready = 1'b1;
      in_done   = 1'b1;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_err !== 1'b0)
         $display("FAIL %s after_handshake got valid=%b busy=%b err=%b exp 0 0 0",
                  name, out_valid, busy, out_err);
      else passed++;
      bad = 1'b0;
      for (int k = 0; k < (rise_hs ? 12 : 3); k++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      total++;
      if (bad) $display("FAIL %s single_transfer got valid=%b busy=%b exp 0 0",
                        name, out_valid, busy);
      else passed++;
      total++;
      if (q_bcd !== eq || r_bcd !== er)
         $display("FAIL %s idle_retain got q=%h r=%h exp q=%h r=%h", name, q_bcd, r_bcd, eq, er);
      else passed++;
   endtask

   task automatic test_reset();
      bit bad;
      reset = 1'b1; in_done = 1'b1; out_ready = 1'b0;
      in_quotient = 8'd5; in_remainder = 8'd1; in_divisor = 8'd3;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || q_bcd !== 12'h000 || r_bcd !== 12'h000 || out_err !== 1'b0)
         $display("FAIL reset_values got valid=%b busy=%b q=%h r=%h err=%b exp all 0",
                  out_valid, busy, q_bcd, r_bcd, out_err);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
      bad = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      total++;
      if (bad) $display("FAIL reset_done_high_no_capture got valid=%b busy=%b exp 0 0", out_valid, busy);
      else passed++;
   endtask

   task automatic test_directed();
      do_txn(8'd28,  8'd4,  8'd7,   0, 1'b0, "q28_r4");
      do_txn(8'd255, 8'd0,  8'd1,   5, 1'b0, "q255_stall5");
      do_txn(8'd0,   8'd255, 8'd2,  1, 1'b1, "q0_rise_at_handshake");
      do_txn(8'd255, 8'd17, 8'd0,   0, 1'b0, "divzero");
   endtask

   // A second rise during CONV must be dropped.
   task automatic test_drop_in_conv();
      int lat;
      bit bad;
      @(negedge clk);
      in_done = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      in_quotient = 8'd99; in_remainder = 8'd5; in_divisor = 8'd3; in_done = 1'b1;
      @(posedge clk);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 2) in_done = 1'b0;
         if (k == 3) begin
            in_quotient = 8'd200;
            in_done = 1'b1;
         end
         @(posedge clk); #1;
         if (out_valid === 1'b1) begin
            lat = k;
            break;
         end
      end
      total++;
      if (lat != 8 || q_bcd !== 12'h099 || r_bcd !== 12'h005)
         $display("FAIL drop_in_conv got lat=%0d q=%h r=%h exp lat=8 q=099 r=005", lat, q_bcd, r_bcd);
      else passed++;
      bad = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk); #1;
         if (k > 0 && out_valid !== 1'b0) bad = 1'b1;
      end
      total++;
      if (bad) $display("FAIL drop_in_conv_second_valid got valid=%b exp 0", out_valid);
      else passed++;
   endtask

   // Reset in the 4th CONV cycle discards the result.
   task automatic test_reset_mid_conv();
      bit bad;
      @(negedge clk);
      in_done = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      in_quotient = 8'd77; in_remainder = 8'd6; in_divisor = 8'd9; in_done = 1'b1;
      @(posedge clk);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || q_bcd !== 12'h000 || r_bcd !== 12'h000 || out_err !== 1'b0)
         $display("FAIL reset_mid_conv got valid=%b busy=%b q=%h r=%h exp all 0",
                  out_valid, busy, q_bcd, r_bcd);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
      bad = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) bad = 1'b1;
      end
      total++;
      if (bad) $display("FAIL reset_mid_conv_no_pulse got valid=%b exp 0", out_valid);
      else passed++;
      do_txn(8'd10, 8'd3, 8'd5, 0, 1'b0, "after_reset_q10_r3");
   endtask

   task automatic test_random();
      logic [7:0] q, r, dv;
      int         delay;
      bit         rh;
      for (int i = 0; i < 16; i++) begin
         q     = 8'($urandom_range(0, 255));
         r     = 8'($urandom_range(0, 255));
         dv    = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         delay = int'($urandom_range(0, 3));
         rh    = (delay > 0) && ($urandom_range(0, 1) == 1);
         do_txn(q, r, dv, delay, rh, "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_drop_in_conv();
      test_reset_mid_conv();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
